// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 unit: register numbers,
// SR/Cause field positions and the exception codes the core raises.
package cp0_pkg;

  // CP0 register numbers as encoded in mtc0/mfc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Exception codes; zero on the ExcCode input means "no exception"
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // EPC always holds a word address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId, plus the per-cycle interrupt and
// exception evaluation that redirects fetch to the handler. Sits at the
// memory-stage commit point, so Req is combinational and the same edge that
// redirects fetch also latches EPC.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] Din,
  input  logic        en,
  output logic [31:0] Dout,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_next;

  // Interrupts use the raw lines so they are seen with zero latency
  always_comb begin
    int_req  = (|(HWInt & im)) & ie & ~exl;
    exc_req  = (ExcCodeIn != 5'd0) & ~exl;
    Req      = int_req | exc_req;
    epc_next = word_align(BDIn ? (VPC - 32'd4) : VPC);
  end

  // SR: entering the handler sets EXL and discards any same-cycle mtc0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (Req) begin
      exl <= 1'b1;
    end else begin
      if (en && A == REG_SR) begin
        im  <= Din[SR_IM_HI:SR_IM_LO];
        exl <= Din[SR_EXL];
        ie  <= Din[SR_IE];
      end
      if (EXLClr) begin
        exl <= 1'b0;
      end
    end
  end

  // Cause: IP mirrors the lines every cycle, BD/ExcCode capture on entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd       <= BDIn;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
      end
    end
  end

  // EPC: handler entry wins over a software write in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= '0;
    end else if (Req) begin
      epc <= epc_next;
    end else if (en && A == REG_EPC) begin
      epc <= word_align(Din);
    end
  end

  // mfc0 read mux; unimplemented registers and bits read as zero
  always_comb begin
    Dout = '0;
    case (A)
      REG_SR: begin
        Dout[SR_IM_HI:SR_IM_LO] = im;
        Dout[SR_EXL]            = exl;
        Dout[SR_IE]             = ie;
      end
      REG_CAUSE: begin
        Dout[CAUSE_BD]                  = bd;
        Dout[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        Dout[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
      end
      REG_EPC:  Dout = epc;
      REG_PRID: Dout = PRID;
      default:  Dout = '0;
    endcase
  end

  assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_cp0_unit;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] Din;
  logic        en;
  logic [31:0] Dout;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;

  sb_entry_t sb[$];
  int vectors;
  int miscompares;

  cp0_unit #(.PRID(32'h0000_2023)) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .Din(Din),
    .en(en),
    .Dout(Dout),
    .VPC(VPC),
    .BDIn(BDIn),
    .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
    .Req(Req),
    .EPCOut(EPCOut)
  );

  // 20 ns clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference EPC computation
  function automatic logic [31:0] model_epc(input logic [31:0] vpc, input logic bd);
    logic [31:0] v;
    v = bd ? (vpc - 32'd4) : vpc;
    v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic expectVal(input string tag, input logic [31:0] value);
    sb_entry_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    sb_entry_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL sb_empty: observed %h, nothing queued", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  // Drive a full input vector just after the falling edge
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] din,
                               input logic wen, input logic [31:0] vpc,
                               input logic bd, input logic [4:0] exc,
                               input logic [5:0] hw, input logic clr);
    @(negedge clk);
    A         = a;
    Din       = din;
    en        = wen;
    VPC       = vpc;
    BDIn      = bd;
    ExcCodeIn = exc;
    HWInt     = hw;
    EXLClr    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] addr, input string tag, input logic [31:0] value);
    en = 1'b0;
    A  = addr;
    expectVal(tag, value);
    #1;
    checkOutput(Dout);
  endtask

  task automatic checkReq(input string tag, input logic value);
    expectVal(tag, {31'd0, value});
    checkOutput({31'd0, Req});
  endtask

  task automatic checkEpc(input string tag, input logic [31:0] value);
    expectVal(tag, value);
    checkOutput(EPCOut);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    A         = '0;
    Din       = '0;
    en        = 1'b0;
    VPC       = '0;
    BDIn      = 1'b0;
    ExcCodeIn = '0;
    HWInt     = '0;
    EXLClr    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state
    readReg(5'd12, "rst_sr", 32'h0);
    readReg(5'd13, "rst_cause", 32'h0);
    readReg(5'd14, "rst_epc", 32'h0);
    readReg(5'd15, "rst_prid", 32'h0000_2023);
    readReg(5'd3, "rst_unimpl", 32'h0);
    checkReq("rst_req", 1'b0);
    checkEpc("rst_epcout", 32'h0);

    // mtc0 SR; same-cycle mfc0 still returns the old value
    applyStimulus(5'd12, 32'h0000_FC01, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    expectVal("mtc0_sr_old", 32'h0);
    #1;
    checkOutput(Dout);
    tick();
    applyStimulus(5'd12, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    readReg(5'd12, "mtc0_sr_new", 32'h0000_FC01);

    // Interrupt: Req in the same cycle, state latched at the edge
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h3010, 1'b0, 5'd0, 6'b000100, 1'b0);
    #1;
    checkReq("int_req", 1'b1);
    tick();
    checkReq("int_req_after", 1'b0);
    checkEpc("int_epc", 32'h3010);
    readReg(5'd13, "int_cause", 32'h0000_1000);
    readReg(5'd12, "int_sr_exl", 32'h0000_FC03);

    // EXL masks both pending interrupt and exception
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h3040, 1'b0, 5'd4, 6'b000100, 1'b0);
    #1;
    checkReq("exl_masks", 1'b0);

    // eret clears EXL; the pending interrupt fires next cycle with priority
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h3040, 1'b0, 5'd4, 6'b000100, 1'b1);
    #1;
    checkReq("eret_cycle_req", 1'b0);
    tick();
    checkReq("eret_req_rises", 1'b1);
    readReg(5'd12, "eret_sr", 32'h0000_FC01);
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h3040, 1'b0, 5'd4, 6'b000100, 1'b0);
    tick();
    checkEpc("prio_epc", 32'h3040);
    readReg(5'd13, "prio_cause", 32'h0000_1000);

    // Leave the handler
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    readReg(5'd12, "leave_sr", 32'h0000_FC01);
    checkReq("leave_req", 1'b0);

    // Overflow exception in a delay slot
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h3024, 1'b1, 5'd12, 6'd0, 1'b0);
    #1;
    checkReq("ov_req", 1'b1);
    tick();
    checkEpc("ov_epc", model_epc(32'h3024, 1'b1));
    readReg(5'd13, "ov_cause", 32'h8000_0030);

    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // mtc0 EPC colliding with handler entry is discarded
    applyStimulus(5'd14, 32'h0000_3FFF, 1'b1, 32'h3100, 1'b0, 5'd10, 6'd0, 1'b0);
    #1;
    checkReq("coll_req", 1'b1);
    tick();
    checkEpc("coll_epc", model_epc(32'h3100, 1'b0));
    readReg(5'd13, "coll_cause", 32'h0000_0028);

    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // Plain mtc0 EPC is word-aligned
    applyStimulus(5'd14, 32'h0000_3FFF, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    checkEpc("mtc0_epc", 32'h0000_3FFC);
    readReg(5'd14, "mfc0_epc", 32'h0000_3FFC);

    // VPC-4 wraps below zero
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0000_0002, 1'b1, 5'd5, 6'd0, 1'b0);
    #1;
    checkReq("wrap_req", 1'b1);
    tick();
    checkEpc("wrap_epc", model_epc(32'h0000_0002, 1'b1));

    // Writes to Cause and PRId are ignored
    applyStimulus(5'd13, 32'hFFFF_FFFF, 1'b1, 32'h2, 1'b1, 5'd5, 6'd0, 1'b0);
    #1;
    checkReq("exl_req", 1'b0);
    tick();
    applyStimulus(5'd15, 32'h0, 1'b1, 32'h2, 1'b1, 5'd5, 6'd0, 1'b0);
    tick();
    applyStimulus(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'b000100, 1'b0);
    readReg(5'd13, "cause_ro", 32'h8000_0014);
    readReg(5'd15, "prid_ro", 32'h0000_2023);
    readReg(5'd12, "sr_in_handler", 32'h0000_FC03);

    // Asynchronous reset mid-handler takes effect before any edge
    tick();
    reset = 1'b0;
    readReg(5'd12, "async_sr", 32'h0);
    checkReq("async_req", 1'b0);
    checkEpc("async_epc", 32'h0);
    readReg(5'd13, "async_cause", 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC and PRId, serves `mtc0`/`mfc0`/`eret`, and evaluates interrupts and exceptions each cycle. It drives `Req`, the request that redirects the fetch stage to the handler at 0x0000_4180, and supplies `EPCOut` for `eret`. It sits beside the memory-stage pipeline register, which is the macro-instruction commit point.

## Interface
Parameters:
- `PRID`, 32'h0000_2023, value returned for PRId reads.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: reset is asynchronous and active-low; asserting it (0) clears state immediately.
- `A`, in, 5: CP0 register number for `mtc0`/`mfc0`.
- `Din`, in, 32: `mtc0` write data.
- `en`, in, 1: `mtc0` write enable.
- `Dout`, out, 32: `mfc0` read data.
- `VPC`, in, 32: PC of the instruction in the commit stage.
- `BDIn`, in, 1: that instruction sits in a branch delay slot.
- `ExcCodeIn`, in, 5: pending exception code, 0 = none.
- `HWInt`, in, 6: external interrupt lines (timer0, timer1, interrupt generator, …).
- `EXLClr`, in, 1: `eret` committing.
- `Req`, out, 1: redirect fetch to the handler and flush the pipeline.
- `EPCOut`, out, 32: current EPC.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32-bit.
  - PRId (15): `PRID`.
  - Other addresses read 0 and ignore writes.
- `IntReq = |(HWInt & IM) & IE & !EXL`.
- `ExcReq = (ExcCodeIn != 0) & !EXL`.
- `Req = IntReq | ExcReq`. Interrupt has priority over exception.
- On a clock edge with `Req=1`:
  - EXL <= 1.
  - BD <= `BDIn`.
  - ExcCode <= 0 if IntReq, else `ExcCodeIn`.
  - EPC <= (`BDIn` ? `VPC`-4 : `VPC`) with bits [1:0] forced to 0.
- Cause.IP <= `HWInt` every cycle, independent of masks and EXL.
- `mtc0` (`en=1`, `Req=0`) writes SR (IM, EXL, IE only), EPC (bits [1:0] forced 0), or nothing for Cause/PRId. If `Req=1` in the same cycle, the write is discarded.
- `EXLClr=1` with `Req=0` clears EXL. With `EXL=1`, `Req` is necessarily 0, so `eret` cannot collide with a new request.
- `EPCOut` = EPC register.
- `Dout` = combinational read of the register selected by `A`.

## Timing
- Reset values: SR, Cause, EPC = 0. `Req`=0, `EPCOut`=0, and `Dout` = 0 except for `A=15`, where it reads `PRID`.
- `Req` is combinational from the current-cycle inputs and registered SR. It is valid in the same cycle, so the fetch stage redirects at the same edge that latches EPC.
- Register updates take effect at the next rising edge. An `mfc0` in the cycle of a same-address `mtc0` returns the old value.
- Cause.IP lags `HWInt` by one cycle. `IntReq` uses raw `HWInt`, not IP, and has zero latency.
- Reset asserted mid-handler clears EXL. `Req` is then evaluated with IE=0, so it is 0.
- The arithmetic `VPC`-4 wraps modulo 2^32.

## Structure
- Package `cp0_pkg` holds:
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- No sub-module. A single module with one sequential block per register plus combinational `Req`/`Dout` logic.

## Test plan
- Reset, then read all four registers → 0, 0, 0, 32'h0000_2023; `Req`=0.
- `mtc0` SR=32'h0000_FC01, then `HWInt`=6'b000100 with `VPC`=0x3010, `BDIn`=0 → `Req`=1 that cycle; next cycle EPC=0x3010, ExcCode=0, EXL=1, `Req`=0.
- `ExcCodeIn`=12, `BDIn`=1, `VPC`=0x3024, EXL=0 → `Req`=1; EPC=0x3020, BD=1, ExcCode=12.
- EXL=1 with `ExcCodeIn`=4 and an enabled interrupt pending → `Req`=0; then `EXLClr`=1 → next cycle EXL=0 and `Req` rises.
- `mtc0` EPC=0x3FFF in the same cycle as `Req`=1 from `VPC`=0x3100 → EPC=0x3100 (write dropped). A later `mtc0` EPC=0x3FFF → EPC=0x3FFC.
- Assert `reset`=0 between clock edges while EXL=1 → SR reads 0 immediately, before any clock edge.
